// File: rtl/vga_capture.sv
// vga_capture: snoops a VGA pixel stream and writes one decimated frame into memory on request.
//
// Ports:
//   vga_clock     pixel clock, rising edge
//   resetn        asynchronous active-low reset
//   vga_hs/vga_vs active-low horizontal / vertical sync
//   vga_blank     1 = visible pixel
//   vga_r/g/b     10-bit DAC colour levels
//   capture_req   request capture of one frame (sampled while idle)
//   mem_address   write address y*width + x (17 bits for 320x240, 15 bits for 160x120)
//   mem_wren      write strobe
//   mem_data      {r, g, b} top BITS_PER_COLOUR_CHANNEL bits each
//   busy          armed or capturing
//   frame_done    one-cycle pulse when the captured frame ends
//   timing_error  sticky timing mismatch seen during capture
//   line_period   last measured clocks per line
//   frame_lines   last measured lines per frame
module vga_capture #(
   parameter int BITS_PER_COLOUR_CHANNEL = 1,
   parameter     RESOLUTION = "320x240",
   parameter int H_TOTAL = 800,
   parameter int H_PIXELS = 640,
   parameter int V_TOTAL = 525,
   parameter int V_PIXELS = 480,
   localparam int AW = (RESOLUTION == "160x120") ? 15 : 17,
   localparam int B = BITS_PER_COLOUR_CHANNEL
) (
   input  logic          vga_clock,
   input  logic          resetn,
   input  logic          vga_hs,
   input  logic          vga_vs,
   input  logic          vga_blank,
   input  logic [9:0]    vga_r,
   input  logic [9:0]    vga_g,
   input  logic [9:0]    vga_b,
   input  logic          capture_req,
   output logic [AW-1:0] mem_address,
   output logic          mem_wren,
   output logic [3*B-1:0] mem_data,
   output logic          busy,
   output logic          frame_done,
   output logic          timing_error,
   output logic [9:0]    line_period,
   output logic [9:0]    frame_lines
);

   localparam bit QUARTER = (RESOLUTION == "160x120");
   localparam logic [9:0] HT = 10'(H_TOTAL);
   localparam logic [9:0] HP = 10'(H_PIXELS);
   localparam logic [9:0] VT = 10'(V_TOTAL);
   localparam logic [9:0] VP = 10'(V_PIXELS);
   localparam logic [9:0] MASK = QUARTER ? 10'd3 : 10'd1;
   localparam logic [9:0] SAT = 10'd1023;

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURING} state_t;

   state_t state, state_next;

   logic s1_hs, s1_vs, s1_blank;
   logic s2_hs, s2_vs, s2_blank;
   logic [9:0] s1_r, s1_g, s1_b;
   logic hs_fall, vs_fall, blank_fall;

   logic [9:0] px_cnt, line_cnt, h_cyc, v_cnt;
   logic h_valid;

   logic accept, capturing, finish;
   logic wr, err;
   logic [AW-1:0] xa, ya, addr_next;
   logic [3*B-1:0] data_next;
   logic unused_bits;

   // Input stage: one register for everything, a second for edge detection.
   always_ff @(posedge vga_clock or negedge resetn) begin
      if (!resetn) begin
         s1_hs <= 1'b0;
         s1_vs <= 1'b0;
         s1_blank <= 1'b0;
         s1_r <= '0;
         s1_g <= '0;
         s1_b <= '0;
         s2_hs <= 1'b0;
         s2_vs <= 1'b0;
         s2_blank <= 1'b0;
      end else begin
         s1_hs <= vga_hs;
         s1_vs <= vga_vs;
         s1_blank <= vga_blank;
         s1_r <= vga_r;
         s1_g <= vga_g;
         s1_b <= vga_b;
         s2_hs <= s1_hs;
         s2_vs <= s1_vs;
         s2_blank <= s1_blank;
      end
   end

   assign hs_fall = s2_hs & ~s1_hs;
   assign vs_fall = s2_vs & ~s1_vs;
   assign blank_fall = s2_blank & ~s1_blank;

   // Position counters and timing measurement.
   always_ff @(posedge vga_clock or negedge resetn) begin
      if (!resetn) begin
         px_cnt <= '0;
         line_cnt <= '0;
         h_cyc <= '0;
         v_cnt <= '0;
         h_valid <= 1'b0;
         line_period <= '0;
         frame_lines <= '0;
      end else begin
         if (blank_fall)
            px_cnt <= '0;
         else if (s1_blank && px_cnt != SAT)
            px_cnt <= px_cnt + 10'd1;
         if (vs_fall)
            line_cnt <= '0;
         else if (blank_fall && line_cnt != SAT)
            line_cnt <= line_cnt + 10'd1;
         h_cyc <= hs_fall ? 10'd0 : (h_cyc == SAT) ? h_cyc : h_cyc + 10'd1;
         if (hs_fall) begin
            h_valid <= 1'b1;
            if (h_valid)
               line_period <= h_cyc + 10'd1;
         end
         // A coincident HS fall belongs to the new frame, so the count restarts at 1.
         if (vs_fall) begin
            frame_lines <= v_cnt;
            v_cnt <= {9'd0, hs_fall};
         end else if (hs_fall)
            v_cnt <= v_cnt + 10'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge vga_clock or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_next;
   end

   // FSM next state: a VS fall seen while still idle cannot start a capture.
   always_comb begin
      state_next = (state == IDLE && capture_req) ? ARMED :
                   (state == ARMED && vs_fall) ? CAPTURING :
                   (state == CAPTURING && vs_fall) ? IDLE : state;
   end

   // FSM outputs.
   always_comb begin
      busy = (state != IDLE);
      accept = (state == IDLE) && capture_req;
      capturing = (state == CAPTURING);
      finish = capturing && vs_fall;
   end

   assign xa = AW'(QUARTER ? (px_cnt >> 2) : (px_cnt >> 1));
   assign ya = AW'(QUARTER ? (line_cnt >> 2) : (line_cnt >> 1));
   // Multiply by the row width with shifts: 160 = 128 + 32, 320 = 256 + 64.
   assign addr_next = QUARTER ? (ya << 7) + (ya << 5) + xa : (ya << 8) + (ya << 6) + xa;
   assign data_next = {s1_r[9 -: B], s1_g[9 -: B], s1_b[9 -: B]};
   assign unused_bits = ^{s1_r, s1_g, s1_b};

   assign wr = capturing && s1_blank && (px_cnt < HP) && (line_cnt < VP) &&
               ((px_cnt & MASK) == 10'd0) && ((line_cnt & MASK) == 10'd0);

   assign err = (hs_fall && h_valid && (h_cyc + 10'd1) != HT) ||
                (blank_fall && px_cnt != HP) ||
                (vs_fall && line_cnt != VP) ||
                (vs_fall && v_cnt != VT);

   // Memory write port and status flags.
   always_ff @(posedge vga_clock or negedge resetn) begin
      if (!resetn) begin
         mem_wren <= 1'b0;
         mem_address <= '0;
         mem_data <= '0;
         frame_done <= 1'b0;
         timing_error <= 1'b0;
      end else begin
         mem_wren <= wr;
         if (wr) begin
            mem_address <= addr_next;
            mem_data <= data_next;
         end
         frame_done <= finish;
         if (accept)
            timing_error <= 1'b0;
         else if (capturing && err)
            timing_error <= 1'b1;
      end
   end

endmodule
